// File: rtl/sandbox_link_pkg.sv
// Shared types and constants for the sandbox host link layer.
package sandbox_link_pkg;

    localparam int unsigned FRAME_BYTES            = 5;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1000000;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_COLLECT,
        RX_HOLD,
        RX_RELEASE
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_t;

endpackage

// File: rtl/sandbox_frame_tx.sv
// Reply path: transmitData rise detect, {status, outputData} snapshot and
// 5-byte valid/ready serializer.
module sandbox_frame_tx
    import sandbox_link_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_transmit,
    input  logic [7:0]  i_status,
    input  logic [31:0] i_output_data,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [7:0]  o_byte,
    output logic        o_collision
);

    tx_state_t   r_state;
    logic        r_prev;
    logic [39:0] r_shift;
    logic [2:0]  r_idx;
    logic        r_valid;
    logic        r_collision;
    logic        w_rise;

    assign w_rise      = i_transmit & ~r_prev;
    assign o_valid     = r_valid;
    assign o_byte      = r_shift[39:32];
    assign o_collision = r_collision;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= TX_IDLE;
            r_prev      <= 1'b0;
            r_shift     <= '0;
            r_idx       <= '0;
            r_valid     <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_prev      <= i_transmit;
            r_collision <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (w_rise) begin
                        r_shift <= {i_status, i_output_data};
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    // A rise while busy never touches the snapshot in flight.
                    if (w_rise) begin
                        r_collision <= 1'b1;
                    end
                    if (r_valid && i_ready) begin
                        r_shift <= {r_shift[31:0], 8'h00};
                        if (r_idx == 3'(FRAME_BYTES - 1)) begin
                            r_idx   <= '0;
                            r_valid <= 1'b0;
                            r_state <= TX_IDLE;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sandbox_link_controller.sv
// Host-side link layer: assembles 5-byte host frames for the sandbox and
// hands reply serialization to sandbox_frame_tx.
module sandbox_link_controller
    import sandbox_link_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        masterClock,
    input  logic        reset,
    input  logic        rxByteValid,
    input  logic [7:0]  rxByte,
    input  logic        txByteReady,
    output logic        txByteValid,
    output logic [7:0]  txByte,
    output logic        dataReceived,
    output logic [7:0]  control,
    output logic [31:0] inputData,
    input  logic        clearDR,
    input  logic        transmitData,
    input  logic [7:0]  status,
    input  logic [31:0] outputData,
    output logic        frameError,
    output logic        rxOverrun,
    output logic        txCollision
);

    rx_state_t            r_rx_state;
    logic [2:0]           r_count;
    logic [TIMEOUT_W-1:0] r_gap;
    logic [7:0]           r_control;
    logic [31:0]          r_input_data;
    logic                 r_data_received;
    logic                 r_frame_error;
    logic                 r_rx_overrun;

    assign control      = r_control;
    assign inputData    = r_input_data;
    assign dataReceived = r_data_received;
    assign frameError   = r_frame_error;
    assign rxOverrun    = r_rx_overrun;

    always_ff @(posedge masterClock) begin
        if (reset) begin
            r_rx_state      <= RX_IDLE;
            r_count         <= '0;
            r_gap           <= '0;
            r_control       <= '0;
            r_input_data    <= '0;
            r_data_received <= 1'b0;
            r_frame_error   <= 1'b0;
            r_rx_overrun    <= 1'b0;
        end else begin
            r_frame_error <= 1'b0;
            r_rx_overrun  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (rxByteValid) begin
                        r_control  <= rxByte;
                        r_count    <= 3'd1;
                        r_gap      <= '0;
                        r_rx_state <= RX_COLLECT;
                    end
                end
                RX_COLLECT: begin
                    // An arriving byte takes priority over an expiring gap.
                    if (rxByteValid) begin
                        r_input_data <= {r_input_data[23:0], rxByte};
                        r_gap        <= '0;
                        if (r_count == 3'(FRAME_BYTES - 1)) begin
                            r_count         <= '0;
                            r_data_received <= 1'b1;
                            r_rx_state      <= RX_HOLD;
                        end else begin
                            r_count <= r_count + 3'd1;
                        end
                    end else if (r_gap == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_frame_error <= 1'b1;
                        r_count       <= '0;
                        r_gap         <= '0;
                        r_rx_state    <= RX_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                RX_HOLD: begin
                    if (rxByteValid) begin
                        r_rx_overrun <= 1'b1;
                    end
                    if (clearDR) begin
                        r_data_received <= 1'b0;
                        r_rx_state      <= RX_RELEASE;
                    end
                end
                RX_RELEASE: begin
                    if (rxByteValid) begin
                        r_rx_overrun <= 1'b1;
                    end
                    if (!clearDR) begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    sandbox_frame_tx u_frame_tx (
        .i_clk         (masterClock),
        .i_rst         (reset),
        .i_transmit    (transmitData),
        .i_status      (status),
        .i_output_data (outputData),
        .i_ready       (txByteReady),
        .o_valid       (txByteValid),
        .o_byte        (txByte),
        .o_collision   (txCollision)
    );

endmodule

// File: tb/tb_sandbox_link_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based behavioural model of the link layer.
module tb_sandbox_link_controller;

    localparam int TO = 16;

    logic        masterClock = 1'b0;
    logic        reset = 1'b1;
    logic        rxByteValid = 1'b0;
    logic [7:0]  rxByte = '0;
    logic        txByteReady = 1'b0;
    logic        txByteValid;
    logic [7:0]  txByte;
    logic        dataReceived;
    logic [7:0]  control;
    logic [31:0] inputData;
    logic        clearDR = 1'b0;
    logic        transmitData = 1'b0;
    logic [7:0]  status = '0;
    logic [31:0] outputData = '0;
    logic        frameError;
    logic        rxOverrun;
    logic        txCollision;

    sandbox_link_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .masterClock  (masterClock),
        .reset        (reset),
        .rxByteValid  (rxByteValid),
        .rxByte       (rxByte),
        .txByteReady  (txByteReady),
        .txByteValid  (txByteValid),
        .txByte       (txByte),
        .dataReceived (dataReceived),
        .control      (control),
        .inputData    (inputData),
        .clearDR      (clearDR),
        .transmitData (transmitData),
        .status       (status),
        .outputData   (outputData),
        .frameError   (frameError),
        .rxOverrun    (rxOverrun),
        .txCollision  (txCollision)
    );

    always #5 masterClock = ~masterClock;

    int n_checks = 0;
    int n_errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int col_cnt = 0;
    bit cmp_en = 1'b0;

    // Behavioural model: partial frame as a byte count, reply as a byte queue.
    logic [7:0]  m_control = '0;
    logic [31:0] m_inputData = '0;
    bit          m_dr = 1'b0;
    bit          m_wait_clear = 1'b0;
    bit          m_wait_release = 1'b0;
    int          m_nbytes = 0;
    int          m_gap = 0;
    bit          m_fe = 1'b0;
    bit          m_ov = 1'b0;
    bit          m_col = 1'b0;
    bit          m_prev = 1'b0;
    logic [7:0]  txq[$];
    logic [7:0]  cap[$];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit rise;
        if (!reset && txByteValid && txByteReady) cap.push_back(txByte);
        m_fe = 1'b0; m_ov = 1'b0; m_col = 1'b0;
        if (reset) begin
            m_control = '0; m_inputData = '0; m_dr = 1'b0;
            m_wait_clear = 1'b0; m_wait_release = 1'b0;
            m_nbytes = 0; m_gap = 0; txq.delete();
            m_prev = 1'b0;
        end else begin
            if (m_wait_clear || m_wait_release) begin
                if (rxByteValid) m_ov = 1'b1;
                if (m_wait_clear && clearDR) begin
                    m_wait_clear = 1'b0; m_wait_release = 1'b1; m_dr = 1'b0;
                end else if (m_wait_release && !clearDR) begin
                    m_wait_release = 1'b0;
                end
            end else if (rxByteValid) begin
                if (m_nbytes == 0) m_control = rxByte;
                else m_inputData = {m_inputData[23:0], rxByte};
                m_nbytes++; m_gap = 0;
                if (m_nbytes == 5) begin
                    m_nbytes = 0; m_dr = 1'b1; m_wait_clear = 1'b1;
                end
            end else if (m_nbytes > 0) begin
                m_gap++;
                if (m_gap == TO) begin
                    m_fe = 1'b1; m_nbytes = 0; m_gap = 0;
                end
            end
            rise = transmitData && !m_prev;
            if (txq.size() > 0) begin
                if (rise) m_col = 1'b1;
                if (txByteReady) void'(txq.pop_front());
            end else if (rise) begin
                txq.push_back(status);
                txq.push_back(outputData[31:24]);
                txq.push_back(outputData[23:16]);
                txq.push_back(outputData[15:8]);
                txq.push_back(outputData[7:0]);
            end
            m_prev = transmitData;
        end
    endtask

    initial forever begin
        @(posedge masterClock);
        model_step();
        cmp_en = 1'b1;
    end

    initial forever begin
        @(negedge masterClock);
        if (cmp_en) begin
            if (frameError === 1'b1) fe_cnt++;
            if (rxOverrun === 1'b1) ov_cnt++;
            if (txCollision === 1'b1) col_cnt++;
            chk("dataReceived", 40'(dataReceived), 40'(m_dr));
            chk("control", 40'(control), 40'(m_control));
            chk("inputData", 40'(inputData), 40'(m_inputData));
            chk("frameError", 40'(frameError), 40'(m_fe));
            chk("rxOverrun", 40'(rxOverrun), 40'(m_ov));
            chk("txCollision", 40'(txCollision), 40'(m_col));
            chk("txByteValid", 40'(txByteValid), 40'(txq.size() > 0));
            if (txq.size() > 0) chk("txByte", 40'(txByte), 40'(txq[0]));
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rxByteValid = 1'b1; rxByte = b;
        @(negedge masterClock);
        rxByteValid = 1'b0;
        repeat (gap) @(negedge masterClock);
    endtask

    initial begin
        int fe0, ov0, col0, silence;
        logic [7:0] exp_tx[5];

        repeat (3) @(negedge masterClock);
        chk("reset_txByte", 40'(txByte), 40'h0);
        chk("reset_dr", 40'(dataReceived), 40'h0);
        reset = 1'b0;
        @(negedge masterClock);

        // 1: basic frame with 3-cycle gaps
        send_byte(8'h01, 3); send_byte(8'hDE, 3); send_byte(8'hAD, 3);
        send_byte(8'hBE, 3); send_byte(8'hEF, 0);
        chk("t1_dr", 40'(dataReceived), 40'h1);
        chk("t1_control", 40'(control), 40'h01);
        chk("t1_inputData", 40'(inputData), 40'hDEADBEEF);
        clearDR = 1'b1;
        @(negedge masterClock);
        chk("t1_dr_cleared", 40'(dataReceived), 40'h0);
        clearDR = 1'b0;
        @(negedge masterClock);

        // 2: timeout after two bytes, then boundary gap of TO-1 idle cycles
        fe0 = fe_cnt;
        send_byte(8'h9A, 0); send_byte(8'h9B, TO + 3);
        chk("t2_frameError_count", 40'(fe_cnt - fe0), 40'd1);
        chk("t2_dr", 40'(dataReceived), 40'h0);
        fe0 = fe_cnt;
        send_byte(8'h00, TO - 1); send_byte(8'h11, TO - 1); send_byte(8'h22, TO - 1);
        send_byte(8'h33, TO - 1); send_byte(8'h44, 1);
        chk("t2_no_timeout", 40'(fe_cnt - fe0), 40'd0);
        chk("t2_dr_set", 40'(dataReceived), 40'h1);
        chk("t2_inputData", 40'(inputData), 40'h11223344);

        // 3: byte while frame held
        ov0 = ov_cnt;
        send_byte(8'h55, 2);
        chk("t3_overrun", 40'(ov_cnt - ov0), 40'd1);
        chk("t3_control", 40'(control), 40'h00);
        chk("t3_inputData", 40'(inputData), 40'h11223344);
        clearDR = 1'b1; @(negedge masterClock);
        clearDR = 1'b0; @(negedge masterClock);

        // 4: reply with ready toggling; snapshot isolates later input changes
        cap.delete();
        status = 8'hA5; outputData = 32'h12345678; transmitData = 1'b1; txByteReady = 1'b0;
        @(negedge masterClock);
        status = 8'hFF; outputData = 32'h0;
        for (int i = 0; i < 14; i++) begin
            txByteReady = ~txByteReady;
            @(negedge masterClock);
        end
        txByteReady = 1'b0; transmitData = 1'b0;
        @(negedge masterClock);
        exp_tx = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78};
        chk("t4_count", 40'(cap.size()), 40'd5);
        for (int i = 0; i < 5; i++)
            if (i < cap.size()) chk("t4_byte", 40'(cap[i]), 40'(exp_tx[i]));
        chk("t4_valid_low", 40'(txByteValid), 40'h0);

        // 5: collision during reply, then level held high
        cap.delete(); col0 = col_cnt;
        status = 8'h3C; outputData = 32'hCAFEF00D; transmitData = 1'b1;
        repeat (2) @(negedge masterClock);
        transmitData = 1'b0; @(negedge masterClock);
        transmitData = 1'b1; status = 8'h00; repeat (2) @(negedge masterClock);
        chk("t5_collision", 40'(col_cnt - col0), 40'd1);
        txByteReady = 1'b1;
        repeat (12) @(negedge masterClock);
        exp_tx = '{8'h3C, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        chk("t5_count", 40'(cap.size()), 40'd5);
        for (int i = 0; i < 5; i++)
            if (i < cap.size()) chk("t5_byte", 40'(cap[i]), 40'(exp_tx[i]));
        chk("t5_no_retx", 40'(txByteValid), 40'h0);

        // 6: reset mid-frame and mid-reply
        txByteReady = 1'b0; transmitData = 1'b0; @(negedge masterClock);
        status = 8'h77; outputData = 32'h89ABCDEF; transmitData = 1'b1;
        @(negedge masterClock);
        txByteReady = 1'b1; repeat (2) @(negedge masterClock);
        txByteReady = 1'b0;
        send_byte(8'hE1, 0); send_byte(8'hE2, 0); send_byte(8'hE3, 0);
        fe0 = fe_cnt; ov0 = ov_cnt; col0 = col_cnt;
        reset = 1'b1; transmitData = 1'b0;
        @(negedge masterClock);
        chk("t6_all_zero", {dataReceived, txByteValid, frameError, rxOverrun, txCollision,
                            control, inputData[31:5]} , 40'h0);
        chk("t6_inputData", 40'(inputData), 40'h0);
        chk("t6_txByte", 40'(txByte), 40'h0);
        reset = 1'b0;
        @(negedge masterClock);
        send_byte(8'hC3, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
        send_byte(8'h03, 0); send_byte(8'h04, 1);
        chk("t6_no_pulses", 40'((fe_cnt - fe0) + (ov_cnt - ov0) + (col_cnt - col0)), 40'd0);
        chk("t6_control", 40'(control), 40'hC3);
        chk("t6_inputData_fresh", 40'(inputData), 40'h01020304);
        clearDR = 1'b1; @(negedge masterClock);
        clearDR = 1'b0; @(negedge masterClock);

        // Randomized traffic against the model
        silence = 0;
        for (int c = 0; c < 4000; c++) begin
            if (silence > 0) begin
                silence--;
                rxByteValid = 1'b0;
            end else begin
                rxByteValid = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 40) == 0) silence = $urandom_range(12, 20);
            end
            rxByte = 8'($urandom);
            if ($urandom_range(0, 5) == 0) clearDR = ~clearDR;
            if ($urandom_range(0, 9) == 0) transmitData = ~transmitData;
            txByteReady = $urandom_range(0, 1) == 1;
            status = 8'($urandom);
            outputData = $urandom;
            reset = ($urandom_range(0, 599) == 0);
            @(negedge masterClock);
        end
        reset = 1'b0; rxByteValid = 1'b0;
        @(negedge masterClock);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
